// File: rtl/spmm_pkg.sv
// Shared types and sizing for the sparse SPMM/SPV CSR datapath.
package spmm_pkg;

   localparam int DATA_WIDTH     = 8;
   localparam int H_NUM_OF_COLS  = 5;
   localparam int H_NUM_OF_ROWS  = 5;
   localparam int COL_IDX_WIDTH  = $clog2(H_NUM_OF_COLS);
   localparam int ROW_LEN_WIDTH  = $clog2(H_NUM_OF_COLS + 1);
   localparam int ROW_INFO_WIDTH = ROW_LEN_WIDTH + 1;
   localparam int ROW_CNT_WIDTH  = (H_NUM_OF_ROWS > 1) ? $clog2(H_NUM_OF_ROWS) : 1;

   // One nonzero of a CSR row.
   typedef struct packed {
      logic [COL_IDX_WIDTH-1:0] col_idx;
      logic [DATA_WIDTH-1:0]    value;
   } csr_elem_t;

   // Per-row header word: row_len in the upper bits, last_row in bit 0.
   typedef struct packed {
      logic [ROW_LEN_WIDTH-1:0] row_len;
      logic                     last_row;
   } row_info_t;

   typedef enum logic [1:0] {
      SCAN,
      INFO,
      DATA
   } enc_state_e;

endpackage

// File: rtl/csr_row_encoder_if.sv
// Dense-input and CSR-output handshake bundle of the row encoder.
// The slave modport is the encoder; the master modport is its environment.
interface csr_row_encoder_if import spmm_pkg::*; ;

   logic [DATA_WIDTH-1:0]     din_data_i;
   logic                      din_valid_i;
   logic                      din_ready_o;
   logic [ROW_INFO_WIDTH-1:0] info_o;
   logic                      info_valid_o;
   logic                      info_ready_i;
   logic [COL_IDX_WIDTH-1:0]  col_idx_o;
   logic [DATA_WIDTH-1:0]     value_o;
   logic                      elem_valid_o;
   logic                      elem_ready_i;

   modport slave (
      input  din_data_i, din_valid_i, info_ready_i, elem_ready_i,
      output din_ready_o, info_o, info_valid_o, col_idx_o, value_o, elem_valid_o
   );

   modport master (
      output din_data_i, din_valid_i, info_ready_i, elem_ready_i,
      input  din_ready_o, info_o, info_valid_o, col_idx_o, value_o, elem_valid_o
   );

endinterface

// File: rtl/csr_row_buffer.sv
// Synchronous FIFO holding one row's nonzeros in column order.
module csr_row_buffer
   import spmm_pkg::*;
#(
   parameter int DEPTH = H_NUM_OF_COLS
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  csr_elem_t wr_elem,
   input  logic      pop,
   output csr_elem_t rd_elem,
   output logic      full,
   output logic      empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   csr_elem_t          mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               do_push;
   logic               do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_elem = mem[rd_ptr];

   // Write the pushed entry into storage.
   // NOTE: clocked state is written with non-blocking assignments; the storage
   // array has no reset because the pointers and count alone define which
   // entries are live, so clearing those on reset empties the buffer.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_elem;
      end
   end

   // Advance pointers and occupancy; reset discards any partial row.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/csr_row_encoder.sv
// Dense row-major feature stream to CSR row stream: one row_info word per row,
// then that row's nonzeros as (col_idx, value) pairs in ascending column order.
module csr_row_encoder
   import spmm_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   csr_row_encoder_if.slave   bus
);

   enc_state_e                state;
   enc_state_e                state_next;
   logic [COL_IDX_WIDTH-1:0]  col_cnt;
   logic [ROW_CNT_WIDTH-1:0]  row_cnt;
   logic [ROW_LEN_WIDTH-1:0]  nz_cnt;
   logic [ROW_LEN_WIDTH-1:0]  nz_cnt_next;
   row_info_t                 info_q;
   csr_elem_t                 slot_q;
   logic                      slot_valid_q;

   logic                      din_accept;
   logic                      is_nonzero;
   logic                      last_col;
   logic                      info_fire;
   logic                      elem_fire;
   logic                      load_slot;
   logic                      buf_push;
   logic                      buf_full;
   logic                      buf_empty;
   csr_elem_t                 buf_rd;

   csr_row_buffer #(.DEPTH(H_NUM_OF_COLS)) u_row_buffer (
      .clk     (clk),
      .rst     (rst),
      .push    (buf_push),
      .wr_elem ('{col_idx: col_cnt, value: bus.din_data_i}),
      .pop     (load_slot),
      .rd_elem (buf_rd),
      .full    (buf_full),
      .empty   (buf_empty)
   );

   // Ready and info-valid decode straight from the state register, so neither
   // depends combinationally on a consumer ready.
   assign bus.din_ready_o  = (state == SCAN);
   assign bus.info_valid_o = (state == INFO);
   assign bus.info_o       = info_q;
   assign bus.col_idx_o    = slot_q.col_idx;
   assign bus.value_o      = slot_q.value;
   assign bus.elem_valid_o = slot_valid_q;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= SCAN;
      else     state <= state_next;
   end

   // Next state, handshake decode and buffer/slot control.
   // NOTE: every signal written here gets a default first, so each path
   // assigns it and no latch is inferred.
   always_comb begin
      state_next  = state;
      din_accept  = (state == SCAN) && bus.din_valid_i;
      is_nonzero  = (bus.din_data_i != '0);
      last_col    = (col_cnt == COL_IDX_WIDTH'(H_NUM_OF_COLS - 1));
      nz_cnt_next = nz_cnt + ROW_LEN_WIDTH'(is_nonzero);
      info_fire   = (state == INFO) && bus.info_ready_i;
      elem_fire   = slot_valid_q && bus.elem_ready_i;
      buf_push    = din_accept && is_nonzero && !buf_full;
      load_slot   = 1'b0;
      case (state)
         SCAN: begin
            if (din_accept && last_col) state_next = INFO;
         end
         INFO: begin
            if (info_fire) begin
               // Preload the first nonzero with the info handshake so the
               // element stream starts the very next cycle.
               load_slot  = !buf_empty;
               state_next = (info_q.row_len != '0) ? DATA : SCAN;
            end
         end
         DATA: begin
            if (!slot_valid_q || elem_fire) begin
               if (!buf_empty) load_slot  = 1'b1;
               else            state_next = SCAN;
            end
         end
         default: state_next = SCAN;
      endcase
   end

   // Column/row/nonzero counters and the latched row header.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_cnt <= '0;
         row_cnt <= '0;
         nz_cnt  <= '0;
         info_q  <= '0;
      end else begin
         if (din_accept) begin
            if (last_col) begin
               col_cnt <= '0;
               nz_cnt  <= '0;
               info_q  <= '{row_len:  nz_cnt_next,
                            last_row: (row_cnt == ROW_CNT_WIDTH'(H_NUM_OF_ROWS - 1))};
            end else begin
               col_cnt <= col_cnt + COL_IDX_WIDTH'(1);
               nz_cnt  <= nz_cnt_next;
            end
         end
         if (info_fire) begin
            row_cnt <= (row_cnt == ROW_CNT_WIDTH'(H_NUM_OF_ROWS - 1)) ?
                       '0 : row_cnt + ROW_CNT_WIDTH'(1);
         end
      end
   end

   // Registered element output slot; payload holds while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q       <= '0;
         slot_valid_q <= 1'b0;
      end else if (load_slot) begin
         slot_q       <= buf_rd;
         slot_valid_q <= 1'b1;
      end else if (elem_fire) begin
         slot_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_csr_row_encoder.sv
// Self-checking bench for csr_row_encoder: table of rows with expected headers,
// a scoreboard of expected nonzeros, and a hand-written reset-mid-emit sequence.
module tb_csr_row_encoder;
   import spmm_pkg::*;

   typedef enum logic [1:0] {RDY_ALWAYS, RDY_RANDOM, RDY_MANUAL} rdy_mode_e;
   typedef logic [H_NUM_OF_COLS-1:0][DATA_WIDTH-1:0] row_t;

   typedef struct {
      row_t                     row;
      logic [ROW_LEN_WIDTH-1:0] exp_len;
      logic                     exp_last;
      rdy_mode_e                mode;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   csr_row_encoder_if bus ();

   csr_row_encoder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   row_info_t exp_info_q [$];
   csr_elem_t exp_elem_q [$];

   rdy_mode_e rdy_mode    = RDY_ALWAYS;
   logic      manual_info = 1'b0;
   logic      manual_elem = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   // Consumer ready generator, updated 2 time units after each rising edge.
   initial begin
      bus.info_ready_i = 1'b0;
      bus.elem_ready_i = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            RDY_ALWAYS: begin
               bus.info_ready_i = 1'b1;
               bus.elem_ready_i = 1'b1;
            end
            RDY_RANDOM: begin
               bus.info_ready_i = 1'($urandom_range(0, 1));
               bus.elem_ready_i = 1'($urandom_range(0, 1));
            end
            default: begin
               bus.info_ready_i = manual_info;
               bus.elem_ready_i = manual_elem;
            end
         endcase
      end
   end

   // Output monitor: sampled on the falling edge, compares handshakes with the
   // scoreboard and checks hold/throughput properties.
   logic      prev_info_stall = 1'b0;
   logic      prev_elem_stall = 1'b0;
   row_info_t prev_info;
   csr_elem_t prev_elem;
   logic      expect_scan = 1'b0;
   logic      expect_elem = 1'b0;
   int        remaining   = 0;

   always @(negedge clk) begin
      if (rst) begin
         prev_info_stall = 1'b0;
         prev_elem_stall = 1'b0;
         expect_scan     = 1'b0;
         expect_elem     = 1'b0;
         remaining       = 0;
      end else begin
         if (prev_info_stall) begin
            check("info_hold_valid", bus.info_valid_o, 1);
            check("info_hold_payload", bus.info_o, prev_info);
         end
         if (prev_elem_stall) begin
            check("elem_hold_valid", bus.elem_valid_o, 1);
            check("elem_hold_payload", {bus.col_idx_o, bus.value_o}, prev_elem);
         end
         if (expect_scan) check("scan_after_empty_row", bus.din_ready_o, 1);
         if (expect_elem) check("elem_back_to_back", bus.elem_valid_o, 1);
         if (bus.info_valid_o || bus.elem_valid_o)
            check("din_ready_low_while_emitting", bus.din_ready_o, 0);
         expect_scan = 1'b0;
         expect_elem = 1'b0;

         if (bus.info_valid_o && bus.info_ready_i) begin
            if (exp_info_q.size() == 0) begin
               fail_now("unexpected_info");
            end else begin
               row_info_t e;
               e = exp_info_q.pop_front();
               check("info", bus.info_o, e);
               remaining   = int'(e.row_len);
               expect_scan = (e.row_len == '0);
               expect_elem = (e.row_len != '0) && (rdy_mode == RDY_ALWAYS);
            end
         end

         if (bus.elem_valid_o && bus.elem_ready_i) begin
            if (exp_elem_q.size() == 0) begin
               fail_now("unexpected_elem");
            end else begin
               csr_elem_t e;
               e = exp_elem_q.pop_front();
               check("elem", {bus.col_idx_o, bus.value_o}, e);
               remaining   = remaining - 1;
               expect_elem = (remaining > 0) && (rdy_mode == RDY_ALWAYS);
            end
         end

         prev_info_stall = bus.info_valid_o && !bus.info_ready_i;
         prev_elem_stall = bus.elem_valid_o && !bus.elem_ready_i;
         prev_info       = bus.info_o;
         prev_elem       = '{col_idx: bus.col_idx_o, value: bus.value_o};
      end
   end

   function automatic vec_t mk(input logic [7:0] c0, c1, c2, c3, c4,
                               input int len, input logic last, input rdy_mode_e m);
      vec_t v;
      v.row[0]   = c0;
      v.row[1]   = c1;
      v.row[2]   = c2;
      v.row[3]   = c3;
      v.row[4]   = c4;
      v.exp_len  = ROW_LEN_WIDTH'(len);
      v.exp_last = last;
      v.mode     = m;
      return v;
   endfunction

   // Push the expected header and nonzeros, then stream the dense row in.
   task automatic drive_row(input row_t r, input logic [ROW_LEN_WIDTH-1:0] len, input logic last);
      exp_info_q.push_back('{row_len: len, last_row: last});
      for (int c = 0; c < H_NUM_OF_COLS; c++)
         if (r[c] != '0) exp_elem_q.push_back('{col_idx: COL_IDX_WIDTH'(c), value: r[c]});
      for (int c = 0; c < H_NUM_OF_COLS; c++) begin
         int n = 0;
         bus.din_valid_i = 1'b1;
         bus.din_data_i  = r[c];
         forever begin
            @(negedge clk);
            if (bus.din_ready_o) break;
            n++;
            if (n > 300) begin
               fail_now("din_ready_timeout");
               bus.din_valid_i = 1'b0;
               return;
            end
         end
         @(posedge clk);
         #1;
      end
      bus.din_valid_i = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_info_q.size() != 0 || exp_elem_q.size() != 0) && n < 600) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard_drained", (exp_info_q.size() == 0) && (exp_elem_q.size() == 0), 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "bench timed out");
   end

   vec_t vecs [6];

   initial begin
      vecs[0] = mk(0,   3,   0,   0,   5, 2, 1'b0, RDY_ALWAYS);
      vecs[1] = mk(0,   0,   0,   0,   0, 0, 1'b0, RDY_ALWAYS);
      vecs[2] = mk(1,   2,   3,   4, 255, 5, 1'b0, RDY_ALWAYS);
      vecs[3] = mk(7,   0,   9,   0,   0, 2, 1'b0, RDY_RANDOM);
      vecs[4] = mk(0,   0,   0,   2,   0, 1, 1'b1, RDY_RANDOM);
      vecs[5] = mk(9,   9,   0,   0,   0, 2, 1'b0, RDY_ALWAYS);

      bus.din_valid_i = 1'b0;
      bus.din_data_i  = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_din_ready", bus.din_ready_o, 1);
      check("reset_info_valid", bus.info_valid_o, 0);
      check("reset_elem_valid", bus.elem_valid_o, 0);
      check("reset_info", bus.info_o, 0);
      check("reset_col_idx", bus.col_idx_o, 0);
      check("reset_value", bus.value_o, 0);
      @(posedge clk);
      #1;

      // Table rows, streamed back to back while the ready mode is unchanged.
      for (int i = 0; i < 6; i++) begin
         if (i > 0 && vecs[i].mode != vecs[i-1].mode) wait_drain();
         rdy_mode = vecs[i].mode;
         drive_row(vecs[i].row, vecs[i].exp_len, vecs[i].exp_last);
      end
      wait_drain();

      // Reset in the middle of emitting a row after one element is taken.
      rdy_mode    = RDY_MANUAL;
      manual_info = 1'b1;
      manual_elem = 1'b0;
      @(posedge clk);
      #1;
      exp_info_q.push_back('{row_len: 3'd3, last_row: 1'b0});
      exp_elem_q.push_back('{col_idx: 3'd0, value: 8'd6});
      begin
         row_t r;
         r[0] = 8'd6; r[1] = 8'd0; r[2] = 8'd8; r[3] = 8'd0; r[4] = 8'd9;
         for (int c = 0; c < H_NUM_OF_COLS; c++) begin
            int n = 0;
            bus.din_valid_i = 1'b1;
            bus.din_data_i  = r[c];
            while (!bus.din_ready_o && n < 50) begin
               @(negedge clk);
               n++;
            end
            @(posedge clk);
            #1;
         end
         bus.din_valid_i = 1'b0;
      end
      begin
         int n = 0;
         @(negedge clk);
         while (!bus.elem_valid_o && n < 50) begin
            @(negedge clk);
            n++;
         end
         check("mid_row_elem_valid", bus.elem_valid_o, 1);
      end
      @(posedge clk);
      #1 manual_elem = 1'b1;
      @(posedge clk);
      #1;
      manual_elem = 1'b0;
      rst         = 1'b1;
      #1;
      check("rst_drops_info_valid", bus.info_valid_o, 0);
      check("rst_drops_elem_valid", bus.elem_valid_o, 0);
      check("rst_pending_expectations", exp_info_q.size() + exp_elem_q.size(), 0);
      exp_info_q.delete();
      exp_elem_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      rdy_mode = RDY_ALWAYS;
      @(negedge clk);
      check("post_rst_din_ready", bus.din_ready_o, 1);
      @(posedge clk);
      #1;

      // Fresh start: last_row must appear on the 5th row after reset.
      for (int i = 0; i < 5; i++) begin
         row_t r;
         if (i < 4) begin
            r[0] = 8'd0; r[1] = 8'd0; r[2] = 8'd4; r[3] = 8'd0; r[4] = 8'd0;
         end else begin
            r[0] = 8'd1; r[1] = 8'd0; r[2] = 8'd0; r[3] = 8'd0; r[4] = 8'd0;
         end
         drive_row(r, 3'd1, (i == 4));
      end
      wait_drain();
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
